// File: rtl/cpu_pkg.sv
// Shared pipeline types and constants for the CPU datapath.
package cpu_pkg;

   localparam int XLEN = 32;

   // Internal ALU operation codes produced by the ALU-control decode.
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   // Operand-forwarding selects; 2'b11 also falls back to the register file.
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic       WB_reg_write;
      logic       WB_mem_to_reg;
      logic       M_branch;
      logic       M_mem_read;
      logic       M_mem_write;
      logic       EX_ALU_Src;
      logic [1:0] EX_ALU_Op;
   } pipeline_control_t_id_ex;

   typedef struct packed {
      logic [31:0] pc_address;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [3:0]  funct;      // {funct7[5], funct3}
      logic [4:0]  rd;
   } pipeline_data_t_id_ex;

   typedef struct packed {
      logic WB_reg_write;
      logic WB_mem_to_reg;
      logic M_branch;
      logic M_mem_read;
      logic M_mem_write;
   } pipeline_control_t_ex_mem;

   typedef struct packed {
      logic [31:0] branch_target;
      logic        zero;
      logic [31:0] alu_result;
      logic [31:0] store_data;
      logic [4:0]  rd;
   } pipeline_data_t_ex_mem;

endpackage

// File: rtl/ex_alu.sv
// ALU-control decode followed by a 32-bit ALU. Purely combinational.
module ex_alu
   import cpu_pkg::*;
(
   input  logic [1:0]  alu_op,
   input  logic [3:0]  funct,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        zero
);

   logic [3:0] alu_ctrl;

   // Map ALU_Op (and funct bits for R-type) onto an internal opcode.
   always_comb begin
      alu_ctrl = ALU_ADD;
      case (alu_op)
         2'b00: alu_ctrl = ALU_ADD;
         2'b01: alu_ctrl = ALU_SUB;
         2'b10: begin
            case (funct)
               4'b0000: alu_ctrl = ALU_ADD;
               4'b1000: alu_ctrl = ALU_SUB;
               4'b0111: alu_ctrl = ALU_AND;
               4'b0110: alu_ctrl = ALU_OR;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         default: alu_ctrl = ALU_ADD;
      endcase
   end

   // Arithmetic wraps modulo 2^32; no overflow is reported.
   always_comb begin
      result = a + b;
      case (alu_ctrl)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         default: result = a + b;
      endcase
      zero = (result == 32'd0);
   end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage: operand forwarding, ALU, branch target, and the EX/MEM
// pipeline register with stall (hold) and flush (bubble) from hazard logic.
module ex_mem_stage
   import cpu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     id_ex_valid,
   input  pipeline_control_t_id_ex  id_ex_ctrl,
   input  pipeline_data_t_id_ex     id_ex_data,
   input  logic [1:0]               fwd_a,
   input  logic [1:0]               fwd_b,
   input  logic [XLEN-1:0]          wb_result,
   input  logic [XLEN-1:0]          mem_alu_result,
   input  logic                     stall,
   input  logic                     flush,
   output logic                     ex_mem_valid,
   output pipeline_control_t_ex_mem ex_mem_ctrl,
   output pipeline_data_t_ex_mem    ex_mem_data
);

   logic [31:0]              op_a;
   logic [31:0]              fwd_rs2;
   logic [31:0]              op_b;
   logic [31:0]              alu_result;
   logic                     alu_zero;
   pipeline_control_t_ex_mem ctrl_next;
   pipeline_data_t_ex_mem    data_next;

   // Forwarding muxes; 2'b11 is treated the same as the register file.
   always_comb begin
      case (fwd_a)
         FWD_WB:  op_a = wb_result;
         FWD_MEM: op_a = mem_alu_result;
         default: op_a = id_ex_data.rs1_data;
      endcase
      case (fwd_b)
         FWD_WB:  fwd_rs2 = wb_result;
         FWD_MEM: fwd_rs2 = mem_alu_result;
         default: fwd_rs2 = id_ex_data.rs2_data;
      endcase
      op_b = id_ex_ctrl.EX_ALU_Src ? id_ex_data.imm : fwd_rs2;
   end

   ex_alu u_alu (
      .alu_op (id_ex_ctrl.EX_ALU_Op),
      .funct  (id_ex_data.funct),
      .a      (op_a),
      .b      (op_b),
      .result (alu_result),
      .zero   (alu_zero)
   );

   // Next EX/MEM contents; a non-valid instruction carries no control.
   always_comb begin
      ctrl_next = '0;
      if (id_ex_valid) begin
         ctrl_next.WB_reg_write  = id_ex_ctrl.WB_reg_write;
         ctrl_next.WB_mem_to_reg = id_ex_ctrl.WB_mem_to_reg;
         ctrl_next.M_branch      = id_ex_ctrl.M_branch;
         ctrl_next.M_mem_read    = id_ex_ctrl.M_mem_read;
         ctrl_next.M_mem_write   = id_ex_ctrl.M_mem_write;
      end
      data_next.branch_target = id_ex_data.pc_address + (id_ex_data.imm << 1);
      data_next.zero          = alu_zero;
      data_next.alu_result    = alu_result;
      data_next.store_data    = fwd_rs2;
      data_next.rd            = id_ex_data.rd;
   end

   // EX/MEM register: flush beats stall; data still loads on a flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_mem_valid <= 1'b0;
         ex_mem_ctrl  <= '0;
         ex_mem_data  <= '0;
      end else if (flush) begin
         ex_mem_valid <= 1'b0;
         ex_mem_ctrl  <= '0;
         ex_mem_data  <= data_next;
      end else if (!stall) begin
         ex_mem_valid <= id_ex_valid;
         ex_mem_ctrl  <= ctrl_next;
         ex_mem_data  <= data_next;
      end
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with a queue-based scoreboard.
module tb_ex_mem_stage;
   import cpu_pkg::*;

   localparam int CW = $bits(pipeline_control_t_ex_mem);
   localparam int DW = $bits(pipeline_data_t_ex_mem);
   localparam int W  = 1 + CW + DW;
   localparam logic [W-1:0] MASK_ALL  = '1;
   localparam logic [W-1:0] MASK_CTRL = {{(1+CW){1'b1}}, {DW{1'b0}}};

   logic                     clk;
   logic                     rst_n;
   logic                     id_ex_valid;
   pipeline_control_t_id_ex  id_ex_ctrl;
   pipeline_data_t_id_ex     id_ex_data;
   logic [1:0]               fwd_a;
   logic [1:0]               fwd_b;
   logic [31:0]              wb_result;
   logic [31:0]              mem_alu_result;
   logic                     stall;
   logic                     flush;
   logic                     ex_mem_valid;
   pipeline_control_t_ex_mem ex_mem_ctrl;
   pipeline_data_t_ex_mem    ex_mem_data;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] mask_q[$];
   string        tag_q[$];
   int           checks;
   int           errors;
   logic [W-1:0] last_exp;

   ex_mem_stage #(.XLEN(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_ex_valid    (id_ex_valid),
      .id_ex_ctrl     (id_ex_ctrl),
      .id_ex_data     (id_ex_data),
      .fwd_a          (fwd_a),
      .fwd_b          (fwd_b),
      .wb_result      (wb_result),
      .mem_alu_result (mem_alu_result),
      .stall          (stall),
      .flush          (flush),
      .ex_mem_valid   (ex_mem_valid),
      .ex_mem_ctrl    (ex_mem_ctrl),
      .ex_mem_data    (ex_mem_data)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] mk_exp(
      input logic v, input logic rw, input logic mtr, input logic br,
      input logic mr, input logic mw, input logic [31:0] bt, input logic z,
      input logic [31:0] alu, input logic [31:0] st, input logic [4:0] rd);
      pipeline_control_t_ex_mem c;
      pipeline_data_t_ex_mem    d;
      c = '{WB_reg_write: rw, WB_mem_to_reg: mtr, M_branch: br,
            M_mem_read: mr, M_mem_write: mw};
      d = '{branch_target: bt, zero: z, alu_result: alu, store_data: st, rd: rd};
      return {v, c, d};
   endfunction

   task automatic drive(
      input logic v, input logic rw, input logic mtr, input logic br,
      input logic mr, input logic mw, input logic src, input logic [1:0] op,
      input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
      input logic [31:0] imm, input logic [3:0] funct, input logic [4:0] rd);
      id_ex_valid = v;
      id_ex_ctrl  = '{WB_reg_write: rw, WB_mem_to_reg: mtr, M_branch: br,
                      M_mem_read: mr, M_mem_write: mw, EX_ALU_Src: src,
                      EX_ALU_Op: op};
      id_ex_data  = '{pc_address: pc, rs1_data: rs1, rs2_data: rs2,
                      imm: imm, funct: funct, rd: rd};
   endtask

   task automatic check_now(input string tag, input logic [W-1:0] e,
                            input logic [W-1:0] m);
      logic [W-1:0] got;
      got = {ex_mem_valid, ex_mem_ctrl, ex_mem_data};
      checks++;
      assert ((got & m) === (e & m)) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got & m, e & m);
      end
   endtask

   // Push the expectation for the current inputs, then compare after the edge.
   task automatic expect_next(input string tag, input logic [W-1:0] e,
                              input logic [W-1:0] m);
      logic [W-1:0] pe;
      logic [W-1:0] pm;
      string        pt;
      exp_q.push_back(e);
      mask_q.push_back(m);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      pe = exp_q.pop_front();
      pm = mask_q.pop_front();
      pt = tag_q.pop_front();
      check_now(pt, pe, pm);
   endtask

   // Directed stimulus
   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      wb_result = 32'd0;
      mem_alu_result = 32'd0;
      drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'd0, 5'd0);
      #2;
      check_now("reset_state", '0, MASK_ALL);
      #10 rst_n = 1'b1;

      // R-type SUB 7-7
      drive(1, 1, 0, 0, 0, 0, 0, 2'b10, 32'h0, 32'd7, 32'd7, 32'h0, 4'b1000, 5'd3);
      expect_next("rtype_sub_zero",
                  mk_exp(1, 1, 0, 0, 0, 0, 32'h0, 1, 32'h0, 32'd7, 5'd3), MASK_ALL);

      // ADD wraps to zero
      drive(1, 1, 0, 0, 0, 0, 0, 2'b00, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 4'b0000, 5'd4);
      expect_next("add_wrap_zero",
                  mk_exp(1, 1, 0, 0, 0, 0, 32'h0, 1, 32'h0, 32'd1, 5'd4), MASK_ALL);

      // Load address: rs1 + imm, control passes through
      drive(1, 1, 1, 0, 1, 0, 1, 2'b00, 32'h20, 32'h100, 32'h55, 32'hFFFF_FFFC, 4'b0010, 5'd9);
      expect_next("load_addr",
                  mk_exp(1, 1, 1, 0, 1, 0, 32'h18, 0, 32'h0FC, 32'h55, 5'd9), MASK_ALL);

      // Forwarding: A from MEM, B from WB, AND
      fwd_a = FWD_MEM;
      fwd_b = FWD_WB;
      mem_alu_result = 32'd5;
      wb_result = 32'd3;
      drive(1, 1, 0, 0, 0, 0, 0, 2'b10, 32'h100, 32'hAAAA, 32'h5555, 32'h4, 4'b0111, 5'd10);
      expect_next("fwd_and",
                  mk_exp(1, 1, 0, 0, 0, 0, 32'h108, 0, 32'd1, 32'd3, 5'd10), MASK_ALL);

      // fwd 2'b11 selects register file; OR
      fwd_a = 2'b11;
      fwd_b = FWD_RF;
      drive(1, 1, 0, 0, 0, 0, 0, 2'b10, 32'h0, 32'hF0, 32'h0F, 32'h0, 4'b0110, 5'd11);
      expect_next("fwd11_or",
                  mk_exp(1, 1, 0, 0, 0, 0, 32'h0, 0, 32'hFF, 32'h0F, 5'd11), MASK_ALL);
      fwd_a = FWD_RF;

      // Unlisted funct decodes as ADD
      drive(1, 1, 0, 0, 0, 0, 0, 2'b10, 32'h0, 32'd2, 32'd3, 32'h0, 4'b0101, 5'd12);
      expect_next("funct_default_add",
                  mk_exp(1, 1, 0, 0, 0, 0, 32'h0, 0, 32'd5, 32'd3, 5'd12), MASK_ALL);

      // ALU_Op 11 is ADD regardless of funct
      drive(1, 1, 0, 0, 0, 0, 0, 2'b11, 32'h0, 32'd10, 32'd3, 32'h0, 4'b1000, 5'd13);
      expect_next("aluop11_add",
                  mk_exp(1, 1, 0, 0, 0, 0, 32'h0, 0, 32'd13, 32'd3, 5'd13), MASK_ALL);

      // ALU_Op 01 is SUB regardless of funct
      drive(1, 0, 0, 0, 0, 1, 0, 2'b01, 32'h0, 32'd9, 32'd4, 32'h0, 4'b0111, 5'd14);
      expect_next("aluop01_sub",
                  mk_exp(1, 0, 0, 0, 0, 1, 32'h0, 0, 32'd5, 32'd4, 5'd14), MASK_ALL);

      // Branch compare and target
      drive(1, 0, 0, 1, 0, 0, 0, 2'b01, 32'h40, 32'h1234, 32'h1234, 32'h10, 4'b0000, 5'd0);
      last_exp = mk_exp(1, 0, 0, 1, 0, 0, 32'h60, 1, 32'h0, 32'h1234, 5'd0);
      expect_next("branch", last_exp, MASK_ALL);

      // Stall three cycles while inputs change
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, 0, 1, 1, i[0], 2'b00, $urandom, $urandom, $urandom, $urandom,
               4'($urandom_range(0, 15)), 5'($urandom_range(1, 31)));
         expect_next($sformatf("stall_hold_%0d", i), last_exp, MASK_ALL);
      end

      // Stall and flush together: bubble
      flush = 1'b1;
      drive(1, 1, 1, 1, 1, 1, 0, 2'b00, 32'h0, 32'd1, 32'd1, 32'h0, 4'b0, 5'd7);
      expect_next("stall_flush_bubble", mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), MASK_CTRL);
      stall = 1'b0;
      flush = 1'b0;

      // Non-valid instruction captures no control but data loads
      drive(0, 1, 1, 1, 1, 1, 0, 2'b00, 32'h0, 32'd1, 32'd2, 32'h0, 4'b0, 5'd8);
      expect_next("invalid_no_ctrl",
                  mk_exp(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'd3, 32'd2, 5'd8), MASK_ALL);

      // Load nonzero state, then reset mid-cycle during a stall
      drive(1, 1, 0, 0, 0, 1, 1, 2'b00, 32'h8, 32'h10, 32'h20, 32'h4, 4'b0, 5'd21);
      expect_next("pre_reset_load",
                  mk_exp(1, 1, 0, 0, 0, 1, 32'h10, 0, 32'h14, 32'h20, 5'd21), MASK_ALL);
      stall = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_now("async_reset_mid_stall", '0, MASK_ALL);
      @(negedge clk);
      rst_n = 1'b1;
      stall = 1'b0;

      // Idle inputs after reset: a zero-operand bubble
      drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0, 5'd0);
      expect_next("post_reset_idle",
                  mk_exp(0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0, 5'd0), MASK_ALL);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage plus EX/MEM pipeline register. Consumes the ID/EX control and data bundles produced by decode, resolves operand forwarding, performs the ALU operation and branch-target computation, and registers the results into the EX/MEM bundles consumed by the memory stage. Supports a stall (hold) and a flush (bubble) from the hazard unit.

## Interface
- `XLEN`, 32: datapath width. Only 32 is supported.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_ex_valid` in 1: ID/EX contents are a real instruction.
- `id_ex_ctrl` in `pipeline_control_t_id_ex`: WB/M/EX control from ID/EX.
- `id_ex_data` in `pipeline_data_t_id_ex`: pc, rs1/rs2 data, imm, funct bits `{funct7[5],funct3}`, rd.
- `fwd_a`, `fwd_b` in 2 each: operand source. 00 = register file, 01 = `wb_result`, 10 = `mem_alu_result`, 11 = register file.
- `wb_result` in 32: value being written back in WB.
- `mem_alu_result` in 32: ALU result currently held in EX/MEM.
- `stall` in 1: hold the EX/MEM register.
- `flush` in 1: load a bubble into EX/MEM.
- `ex_mem_valid` out 1: EX/MEM holds a real instruction.
- `ex_mem_ctrl` out `pipeline_control_t_ex_mem`: WB_reg_write, WB_mem_to_reg, M_branch, M_mem_read, M_mem_write.
- `ex_mem_data` out `pipeline_data_t_ex_mem`: branch_target[31:0], zero, alu_result[31:0], store_data[31:0], rd[4:0].

## Operation
- Operand A = forwarded rs1. Store data = forwarded rs2. Operand B = `imm` if EX_ALU_Src = 1, else forwarded rs2.
- ALU control:
  - EX_ALU_Op 00 → ADD.
  - EX_ALU_Op 01 → SUB.
  - EX_ALU_Op 10 → decode funct bits: 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, any other value ADD.
  - EX_ALU_Op 11 → ADD.
- ADD/SUB are modulo 2^32 with no overflow flag. `zero` = (alu_result == 0).
- branch_target = pc_address + (imm << 1), truncated to 32 bits.
- rd and the WB/M control bits pass through unchanged.
- An instruction with `id_ex_valid` = 0 is captured with all control bits forced to 0.

## Timing
- Latency: one cycle. Outputs reflect the ID/EX inputs sampled at the previous rising edge.
- Reset (async assert, sync release in the system): `ex_mem_valid` = 0, all control bits = 0, all data fields = 0.
- Per edge, in priority order:
  - `flush` = 1: valid = 0 and control = 0. Data fields load normally; their value is don't-care.
  - Else `stall` = 1: every EX/MEM field holds its value.
  - Else: load the new result.
- `flush` and `stall` asserted together: flush wins, so a bubble is loaded.
- A forwarded value is the combinational value of `wb_result`/`mem_alu_result` in the same cycle. No internal forwarding is performed.
- Reset asserted mid-stall clears immediately; the stalled contents are lost.

## Structure
- Add to `cpu_pkg`:
  - `pipeline_control_t_ex_mem` and `pipeline_data_t_ex_mem` packed structs, field order as listed above.
  - 4-bit ALU opcode localparams `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`.
  - Forward-select localparams `FWD_RF`, `FWD_WB`, `FWD_MEM`.
- One sub-module, `ex_alu`: ALU-control decode plus ALU. Inputs are ALU_Op, funct bits, a, b. Outputs are result and zero. Purely combinational.
- The register, stall/flush logic and forwarding muxes live in `ex_mem_stage`.

## Test plan
- Reset: assert `rst_n` = 0 mid-cycle with nonzero state → all outputs 0 immediately, no clock required.
- R-type SUB, no forwarding: ALU_Op 10, funct 1000, rs1 = 7, rs2 = 7 → next cycle alu_result = 0, zero = 1. ADD of 0xFFFFFFFF and 1 → alu_result = 0, zero = 1.
- Load address: ALU_Op 00, ALU_Src 1, rs1 = 0x100, imm = 0xFFFFFFFC → alu_result = 0x0FC, M_mem_read passes through, rd passes through.
- Forwarding: `fwd_a` = 10 with `mem_alu_result` = 5, `fwd_b` = 01 with `wb_result` = 3, funct 0111 → alu_result = 1. Store data equals 3.
- Branch: pc = 0x40, imm = 0x10, ALU_Op 01, rs1 = rs2 → branch_target = 0x60, zero = 1, M_branch = 1.
- Stall/flush:
  - Stall for 3 cycles while inputs change → outputs constant.
  - Stall + flush in the same cycle → valid = 0 and control = 0.
  - `id_ex_valid` = 0 with reg_write = 1 → captured reg_write = 0.
